// File: rtl/adder_pkg.sv
// Shared arithmetic helpers and stage payload type for the pipelined adder family.
package adder_pkg;

  // Widest operand any stage payload can carry; payload fields are sized to this.
  localparam int ADDER_MAX_W = 64;

  // Index width needed to address bit ADDER_MAX_W of a carry-extended vector.
  localparam int ADDER_IDX_W = $clog2(ADDER_MAX_W + 1);

  // One pipeline stage's registered contents. Operand fields hold only the
  // chunks not yet consumed, shifted down so the next chunk sits at bit 0.
  typedef struct packed {
    logic                   valid;
    logic [ADDER_MAX_W-1:0] sumBits;
    logic [ADDER_MAX_W-1:0] aRem;
    logic [ADDER_MAX_W-1:0] bRem;
    logic                   carry;
    logic                   ovf;
  } stage_payload_t;

  // True when the operand width splits evenly into the requested slices.
  function automatic bit adder_params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && (width <= ADDER_MAX_W) &&
           ((width % stages) == 0);
  endfunction

  // Adds the low 'width' bits of a and b plus cin. Returns the carry out of
  // bit width-1 in the top bit and the masked chunk sum in the low bits.
  function automatic logic [ADDER_MAX_W:0] chunk_add(
    input logic [ADDER_MAX_W-1:0] a,
    input logic [ADDER_MAX_W-1:0] b,
    input logic                   cin,
    input logic [ADDER_IDX_W-1:0] width
  );
    logic [ADDER_MAX_W-1:0] mask;
    logic [ADDER_MAX_W:0]   full;
    if (width >= ADDER_IDX_W'(ADDER_MAX_W)) begin
      mask = '1;
    end else begin
      mask = (ADDER_MAX_W'(1) << width) - ADDER_MAX_W'(1);
    end
    full = {1'b0, a & mask} + {1'b0, b & mask} + {{ADDER_MAX_W{1'b0}}, cin};
    return {full[width], full[ADDER_MAX_W-1:0] & mask};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One registered CHUNK-bit slice of the pipelined adder. It resolves the
// lowest unconsumed operand chunk, merges the result into the partial sum at
// OFFSET and hands the carry and remaining operands to the next slice.
module adder_slice
  import adder_pkg::*;
#(
  parameter int CHUNK       = 8,
  parameter int OFFSET      = 0,
  parameter bit COMPUTE_OVF = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_advance,
  input  stage_payload_t i_stage,
  output stage_payload_t o_stage
);

  stage_payload_t         w_next;
  logic [ADDER_MAX_W:0]   w_add;
  logic                   w_msbCarryIn;
  stage_payload_t         r_stage;

  // Resolve this slice's chunk and build the payload the register will capture.
  always_comb begin
    w_next       = i_stage;
    w_add        = chunk_add(i_stage.aRem, i_stage.bRem, i_stage.carry,
                             ADDER_IDX_W'(CHUNK));
    w_msbCarryIn = w_add[CHUNK-1] ^ i_stage.aRem[CHUNK-1] ^ i_stage.bRem[CHUNK-1];
    w_next.sumBits = i_stage.sumBits | (w_add[ADDER_MAX_W-1:0] << OFFSET);
    w_next.aRem    = i_stage.aRem >> CHUNK;
    w_next.bRem    = i_stage.bRem >> CHUNK;
    w_next.carry   = w_add[ADDER_MAX_W];
    if (COMPUTE_OVF) begin
      w_next.ovf = w_msbCarryIn ^ w_add[ADDER_MAX_W];
    end else begin
      w_next.ovf = i_stage.ovf;
    end
  end

  // Stage register: cleared by reset, shifts only when the whole pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
    end else if (i_advance) begin
      r_stage <= w_next;
    end
  end

  assign o_stage = r_stage;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: STAGES carry-chained slices moving in lockstep
// behind a valid/ready handshake, with optional two's-complement overflow.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = (STAGES >= 1) ? (WIDTH / STAGES) : 1;

  if (!adder_params_ok(WIDTH, STAGES)) begin : g_badParams
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, STAGES >= 1, WIDTH <= %0d",
           ADDER_MAX_W);
  end

  // Entry i is the payload feeding slice i; the last entry is the pipe output.
  stage_payload_t w_stage [STAGES+1];
  logic           w_advance;
  logic           w_unusedTail;

  // The pipe moves whenever the output slot is empty or being drained, so a
  // consume and an accept in the same cycle keep full rate.
  assign w_advance = !w_stage[STAGES].valid || out_ready;
  assign in_ready  = w_advance;

  // An advance without in_valid loads a bubble, since valid follows in_valid.
  assign w_stage[0] = '{valid:   in_valid,
                        sumBits: '0,
                        aRem:    ADDER_MAX_W'(a),
                        bRem:    ADDER_MAX_W'(b),
                        carry:   cin,
                        ovf:     1'b0};

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(
      .CHUNK       (CHUNK),
      .OFFSET      (k * CHUNK),
      .COMPUTE_OVF (SIGNED && (k == STAGES - 1))
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .i_advance (w_advance),
      .i_stage   (w_stage[k]),
      .o_stage   (w_stage[k+1])
    );
  end

  assign out_valid = w_stage[STAGES].valid;
  assign sum       = w_stage[STAGES].sumBits[WIDTH-1:0];
  assign cout      = w_stage[STAGES].carry;
  assign ovf       = SIGNED ? w_stage[STAGES].ovf : 1'b0;

  // Operand remnants and padding above WIDTH are always zero at the output.
  assign w_unusedTail = ^w_stage[STAGES];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: scoreboard-driven scenarios on an
// 8-bit/4-stage signed instance plus a 4-bit single-stage instance.
module tb_pipelined_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] opA;
  logic [7:0] opB;
  logic       carryIn;
  logic       outValid;
  logic       outReady;
  logic [7:0] sumOut;
  logic       coutOut;
  logic       ovfOut;

  logic       inValid2;
  logic       inReady2;
  logic [3:0] opA2;
  logic [3:0] opB2;
  logic       carryIn2;
  logic       outValid2;
  logic       outReady2;
  logic [3:0] sumOut2;
  logic       coutOut2;
  logic       ovfOut2;

  exp_t sbQ[$];
  int   compared;
  int   mismatched;

  pipelined_adder #(.WIDTH(8), .STAGES(4), .SIGNED(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (opA),
    .b         (opB),
    .cin       (carryIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .sum       (sumOut),
    .cout      (coutOut),
    .ovf       (ovfOut)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(1), .SIGNED(1'b1)) dutSingle (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid2),
    .in_ready  (inReady2),
    .a         (opA2),
    .b         (opB2),
    .cin       (carryIn2),
    .out_valid (outValid2),
    .out_ready (outReady2),
    .sum       (sumOut2),
    .cout      (coutOut2),
    .ovf       (ovfOut2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: 9-bit add, overflow when like-signed operands give
  // a result of the other sign.
  function automatic exp_t modelAdd(input logic [7:0] x, input logic [7:0] y, input logic c);
    exp_t       e;
    logic [8:0] t;
    t      = {1'b0, x} + {1'b0, y} + {8'b0, c};
    e.sum  = t[7:0];
    e.cout = t[8];
    e.ovf  = (x[7] == y[7]) && (t[7] != x[7]);
    return e;
  endfunction

  // Drive one beat (called at a falling edge); record it if it will be accepted.
  task automatic applyStimulus(input logic v, input logic [7:0] x, input logic [7:0] y,
                               input logic c, input logic rdy);
    inValid  = v;
    opA      = x;
    opB      = y;
    carryIn  = c;
    outReady = rdy;
    #1;
    if (inValid && inReady) sbQ.push_back(modelAdd(x, y, c));
  endtask

  task automatic stepEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b, required 0", outValid); end
    compared++;
    if (sumOut !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_sum: got %h, required 00", sumOut); end
    compared++;
    if (coutOut !== 1'b0 || ovfOut !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_flags: got cout=%b ovf=%b, required 0 0", coutOut, ovfOut);
    end
    rst = 1'b0;
    #1;
    compared++;
    if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b, required 1", inReady); end
  endtask

  task automatic test_carry_ripple();
    exp_t e;
    int   latency;
    latency = 0;
    applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
    stepEdge();
    for (int n = 1; n <= 10; n++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (outValid) begin
        latency = n;
        compared++;
        if (sbQ.size() == 0) begin
          mismatched++; $display("[TB] FAIL ripple_extra: got sum=%h, required no output", sumOut);
        end else begin
          e = sbQ.pop_front();
          if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
            mismatched++;
            $display("[TB] FAIL ripple_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
          end
        end
        break;
      end
      stepEdge();
    end
    compared++;
    if (latency != 4) begin mismatched++; $display("[TB] FAIL ripple_latency: got %0d cycles, required 4", latency); end
    stepEdge();
    sbQ.delete();
  endtask

  task automatic test_signed_overflow();
    exp_t e;
    applyStimulus(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
    stepEdge();
    applyStimulus(1'b1, 8'h80, 8'h80, 1'b0, 1'b1);
    stepEdge();
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (outValid && outReady) begin
        compared++;
        if (sbQ.size() == 0) begin
          mismatched++; $display("[TB] FAIL ovf_extra: got sum=%h, required no output", sumOut);
        end else begin
          e = sbQ.pop_front();
          if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
            mismatched++;
            $display("[TB] FAIL ovf_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
          end
        end
      end
      stepEdge();
    end
    compared++;
    if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL ovf_drain: got %0d pending, required 0", sbQ.size()); end
    sbQ.delete();
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [7:0] iv;
    int         cycle;
    int         lastOut;
    int         outCount;
    int         gaps;
    int         notReady;
    cycle = 0; lastOut = -1; outCount = 0; gaps = 0; notReady = 0;
    for (int n = 0; n < 28; n++) begin
      iv = 8'(n);
      if (n < 16) applyStimulus(1'b1, iv, 8'(2 * n), iv[0], 1'b1);
      else        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (n < 16 && inReady !== 1'b1) notReady++;
      if (outValid && outReady) begin
        if (lastOut >= 0 && cycle != lastOut + 1) gaps++;
        lastOut = cycle;
        outCount++;
        compared++;
        if (sbQ.size() == 0) begin
          mismatched++; $display("[TB] FAIL b2b_extra: got sum=%h, required no output", sumOut);
        end else begin
          e = sbQ.pop_front();
          if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
            mismatched++;
            $display("[TB] FAIL b2b_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
          end
        end
      end
      stepEdge();
      cycle++;
    end
    compared++;
    if (notReady != 0) begin mismatched++; $display("[TB] FAIL b2b_in_ready: got %0d low cycles, required 0", notReady); end
    compared++;
    if (outCount != 16) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d results, required 16", outCount); end
    compared++;
    if (gaps != 0) begin mismatched++; $display("[TB] FAIL b2b_gaps: got %0d gaps, required 0", gaps); end
    sbQ.delete();
  endtask

  task automatic test_backpressure();
    exp_t       e;
    logic [9:0] held;
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 8'($urandom()), 8'($urandom()), 1'($urandom()), 1'b0);
      stepEdge();
    end
    compared++;
    if (outValid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_out_valid: got %b, required 1", outValid); end
    held = {sumOut, coutOut, ovfOut};
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b1, 8'($urandom()), 8'($urandom()), 1'($urandom()), 1'b0);
      compared++;
      if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_in_ready: got %b, required 0", inReady); end
      compared++;
      if ({sumOut, coutOut, ovfOut} !== held) begin
        mismatched++; $display("[TB] FAIL bp_hold: got %h, required %h", {sumOut, coutOut, ovfOut}, held);
      end
      stepEdge();
    end
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (outValid && outReady) begin
        compared++;
        if (sbQ.size() == 0) begin
          mismatched++; $display("[TB] FAIL bp_extra: got sum=%h, required no output", sumOut);
        end else begin
          e = sbQ.pop_front();
          if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
            mismatched++;
            $display("[TB] FAIL bp_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
          end
        end
      end
      stepEdge();
    end
    compared++;
    if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL bp_lost: got %0d pending, required 0", sbQ.size()); end
    sbQ.delete();
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 8'(8'h21 + j), 8'h10, 1'b1, 1'b0);
      stepEdge();
    end
    rst = 1'b1;
    #1;
    compared++;
    if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_out_valid: got %b, required 0", outValid); end
    compared++;
    if (sumOut !== 8'h00) begin mismatched++; $display("[TB] FAIL midrst_sum: got %h, required 00", sumOut); end
    sbQ.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h05, 8'h06, 1'b0, 1'b1);
    stepEdge();
    applyStimulus(1'b1, 8'hC0, 8'h50, 1'b1, 1'b1);
    stepEdge();
    for (int n = 0; n < 12; n++) begin
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (outValid && outReady) begin
        compared++;
        if (sbQ.size() == 0) begin
          mismatched++; $display("[TB] FAIL midrst_extra: got sum=%h, required no output", sumOut);
        end else begin
          e = sbQ.pop_front();
          if ({sumOut, coutOut, ovfOut} !== {e.sum, e.cout, e.ovf}) begin
            mismatched++;
            $display("[TB] FAIL midrst_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     sumOut, coutOut, ovfOut, e.sum, e.cout, e.ovf);
          end
        end
      end
      stepEdge();
    end
    compared++;
    if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL midrst_drain: got %0d pending, required 0", sbQ.size()); end
    sbQ.delete();
  endtask

  task automatic test_single_stage();
    logic [4:0] t;
    logic [3:0] x;
    logic [3:0] y;
    logic       c;
    logic       expOvf;
    x = 4'h9; y = 4'h8; c = 1'b1;
    t      = {1'b0, x} + {1'b0, y} + {4'b0, c};
    expOvf = (x[3] == y[3]) && (t[3] != x[3]);
    inValid2 = 1'b1; opA2 = x; opB2 = y; carryIn2 = c; outReady2 = 1'b1;
    #1;
    compared++;
    if (inReady2 !== 1'b1 || outValid2 !== 1'b0) begin
      mismatched++; $display("[TB] FAIL single_pre: got in_ready=%b out_valid=%b, required 1 0", inReady2, outValid2);
    end
    @(posedge clk);
    @(negedge clk);
    inValid2 = 1'b0;
    #1;
    compared++;
    if (outValid2 !== 1'b1) begin mismatched++; $display("[TB] FAIL single_latency: got out_valid=%b, required 1", outValid2); end
    compared++;
    if ({sumOut2, coutOut2, ovfOut2} !== {t[3:0], t[4], expOvf}) begin
      mismatched++;
      $display("[TB] FAIL single_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               sumOut2, coutOut2, ovfOut2, t[3:0], t[4], expOvf);
    end
    stepEdge();
    compared++;
    if (outValid2 !== 1'b0) begin mismatched++; $display("[TB] FAIL single_drain: got out_valid=%b, required 0", outValid2); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    inValid    = 1'b0; opA  = '0; opB  = '0; carryIn  = 1'b0; outReady  = 1'b0;
    inValid2   = 1'b0; opA2 = '0; opB2 = '0; carryIn2 = 1'b0; outReady2 = 1'b1;
    test_reset();
    test_carry_ripple();
    test_signed_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
